// File: rtl/neuron_train_sequencer_pkg.sv
// Shared types and helpers for the neuron training sequencer.
// zero2one_t is an unsigned 8-bit fraction where 255 means 1.0.
package neuron_train_sequencer_pkg;

  typedef logic [7:0]  zero2one_t;
  typedef logic [7:0]  frac_t;
  typedef logic [23:0] err_acc_t;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEED      = 3'd1;
  localparam logic [2:0] S_PRESENT   = 3'd2;
  localparam logic [2:0] S_SETTLE    = 3'd3;
  localparam logic [2:0] S_CAPTURE   = 3'd4;
  localparam logic [2:0] S_EPOCH_END = 3'd5;
  localparam logic [2:0] S_FINISH    = 3'd6;

  function automatic zero2one_t zero2one_abs_diff(
    input zero2one_t a,
    input zero2one_t b
  );
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic err_acc_t err_sat_add(
    input err_acc_t  acc,
    input zero2one_t d
  );
    logic [24:0] s;
    s = {1'b0, acc} + {17'd0, d};
    return s[24] ? '1 : s[23:0];
  endfunction

endpackage

// File: rtl/neuron_train_sequencer_if.sv
// Control/data bundle between the sequencer and the learning neuron.
// master = sequencer side, slave = neuron side.
interface neuron_train_sequencer_if #(
  parameter int N = 16
);
  import neuron_train_sequencer_pkg::*;

  logic                nl_trigger;
  logic                nl_valid;
  logic                nl_learn;
  zero2one_t [N-1:0]   nl_in;
  zero2one_t           nl_expected_out;
  zero2one_t           nl_out;

  modport master (
    output nl_trigger,
    output nl_valid,
    output nl_learn,
    output nl_in,
    output nl_expected_out,
    input  nl_out
  );

  modport slave (
    input  nl_trigger,
    input  nl_valid,
    input  nl_learn,
    input  nl_in,
    input  nl_expected_out,
    output nl_out
  );

endinterface

// File: rtl/neuron_train_sequencer_mem.sv
// Sample store: DEPTH x (input vector, target), one write port,
// one asynchronous read port. Contents are never reset.
module train_sample_mem
  import neuron_train_sequencer_pkg::*;
#(
  parameter int N     = 16,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  zero2one_t [N-1:0] i_win,
  input  zero2one_t         i_wexp,
  input  logic [AW-1:0]     i_raddr,
  output zero2one_t [N-1:0] o_rin,
  output zero2one_t         o_rexp
);

  zero2one_t [N-1:0] r_in  [DEPTH];
  zero2one_t         r_exp [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_in[i_waddr]  <= i_win;
      r_exp[i_waddr] <= i_wexp;
    end
  end

  assign o_rin  = r_in[i_raddr];
  assign o_rexp = r_exp[i_raddr];

endmodule

// File: rtl/neuron_train_sequencer.sv
// Epoch-based training driver for the combinational learning neuron:
// replays stored samples, sums absolute error, stops on threshold/limit.
module neuron_train_sequencer
  import neuron_train_sequencer_pkg::*;
#(
  parameter int N           = 16,
  parameter int DEPTH       = 32,
  parameter int SETTLE      = 2,
  parameter int SEED_CYCLES = 8,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  zero2one_t [N-1:0] wr_in,
  input  zero2one_t         wr_expected,
  input  logic              start,
  input  logic              learn_en,
  input  logic [AW:0]       n_samples,
  input  logic [15:0]       max_epochs,
  input  logic [23:0]       err_threshold,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [15:0]       epoch_count,
  output logic [23:0]       epoch_err,
  neuron_train_sequencer_if.master nl
);

  localparam logic [AW:0] DEPTH_N     = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_N       = (AW+1)'(1);
  localparam logic [15:0] SEED_LAST   = 16'(SEED_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

  logic [2:0]        r_state;
  logic [15:0]       r_cnt;
  logic [AW-1:0]     r_idx;
  err_acc_t          r_acc;
  err_acc_t          r_err;
  err_acc_t          r_thr;
  logic [15:0]       r_epochs;
  logic [15:0]       r_max;
  logic [AW:0]       r_n;
  logic              r_conv;
  logic              r_lrn_en;
  logic              r_trig;
  logic              r_valid;
  logic              r_learn;
  zero2one_t [N-1:0] r_in;
  zero2one_t         r_exp;

  logic              w_we;
  logic [AW-1:0]     w_raddr;
  zero2one_t [N-1:0] w_rd_in;
  zero2one_t         w_rd_exp;
  logic [AW:0]       w_n_clamp;
  logic              w_trivial;
  logic              w_seed_done;
  logic              w_last;
  logic              w_stop;
  logic              w_load;
  logic              w_seed;
  logic              w_learn_off;
  zero2one_t         w_diff;

  assign w_we    = wr_en && (r_state == S_IDLE);
  assign w_raddr = (r_state == S_CAPTURE) ? r_idx + AW'(1) : '0;

  train_sample_mem #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (wr_addr),
    .i_win   (wr_in),
    .i_wexp  (wr_expected),
    .i_raddr (w_raddr),
    .o_rin   (w_rd_in),
    .o_rexp  (w_rd_exp)
  );

  assign w_n_clamp   = (n_samples > DEPTH_N) ? DEPTH_N : n_samples;
  assign w_trivial   = (w_n_clamp == '0) || (max_epochs == '0);
  assign w_seed_done = (r_cnt == SEED_LAST);
  assign w_last      = ({1'b0, r_idx} == (r_n - ONE_N));
  assign w_stop      = (r_acc <= r_thr) ||
                       ((r_epochs + 16'd1) == r_max);
  assign w_diff      = zero2one_abs_diff(nl.nl_out, r_exp);

  // Neuron-side register update events, decoded from the FSM.
  assign w_load = ((r_state == S_SEED) && w_seed_done) ||
                  ((r_state == S_CAPTURE) && !w_last) ||
                  ((r_state == S_EPOCH_END) && !w_stop);
  assign w_seed = ((r_state == S_IDLE) && start && !w_trivial) ||
                  ((r_state == S_SEED) && !w_seed_done);
  assign w_learn_off = ((r_state == S_CAPTURE) && w_last) ||
                       ((r_state == S_IDLE) && start && w_trivial);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_acc    <= '0;
      r_err    <= '0;
      r_thr    <= '0;
      r_epochs <= '0;
      r_max    <= '0;
      r_n      <= '0;
      r_conv   <= 1'b0;
      r_lrn_en <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_lrn_en <= learn_en;
            r_n      <= w_n_clamp;
            r_max    <= max_epochs;
            r_thr    <= err_threshold;
            r_conv   <= 1'b0;
            r_epochs <= '0;
            r_cnt    <= '0;
            if (w_trivial) begin
              r_err   <= '0;
              r_state <= S_FINISH;
            end else begin
              r_state <= S_SEED;
            end
          end
        end
        S_SEED: begin
          if (w_seed_done) begin
            r_idx   <= '0;
            r_acc   <= '0;
            r_state <= S_PRESENT;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_PRESENT: begin
          r_cnt   <= '0;
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_state <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_CAPTURE: begin
          r_acc <= err_sat_add(r_acc, w_diff);
          if (w_last) begin
            r_state <= S_EPOCH_END;
          end else begin
            r_idx   <= r_idx + AW'(1);
            r_state <= S_PRESENT;
          end
        end
        S_EPOCH_END: begin
          r_err    <= r_acc;
          r_epochs <= r_epochs + 16'd1;
          if (r_acc <= r_thr) begin
            r_conv  <= 1'b1;
            r_state <= S_FINISH;
          end else if (w_stop) begin
            r_state <= S_FINISH;
          end else begin
            r_acc   <= '0;
            r_idx   <= '0;
            r_state <= S_PRESENT;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs to the neuron hold their value unless an event updates them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trig  <= 1'b0;
      r_valid <= 1'b0;
      r_learn <= 1'b0;
      r_in    <= '0;
      r_exp   <= '0;
    end else if (w_load) begin
      r_in    <= w_rd_in;
      r_exp   <= w_rd_exp;
      r_valid <= 1'b1;
      r_learn <= r_lrn_en;
      r_trig  <= ~r_trig;
    end else if (w_seed) begin
      r_valid <= 1'b0;
      r_learn <= 1'b0;
      r_trig  <= ~r_trig;
    end else if (w_learn_off) begin
      r_learn <= 1'b0;
    end
  end

  assign nl.nl_trigger      = r_trig;
  assign nl.nl_valid        = r_valid;
  assign nl.nl_learn        = r_learn;
  assign nl.nl_in           = r_in;
  assign nl.nl_expected_out = r_exp;

  assign busy        = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign done        = (r_state == S_FINISH);
  assign converged   = r_conv;
  assign epoch_count = r_epochs;
  assign epoch_err   = r_err;

endmodule

// File: tb/tb_neuron_train_sequencer.sv
// Directed bench for neuron_train_sequencer: a table of runs with
// hand-computed results plus reset and collision sequences.
module tb_neuron_train_sequencer;
  import neuron_train_sequencer_pkg::*;

  localparam int N     = 16;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  typedef struct {
    int n;
    bit learn;
    int max_ep;
    int thr;
    int out;
    bit disturb;
    bit simwr;
    int simexp;
    int e_err;
    int e_cnt;
    bit e_conv;
    int e_lat;
    int e_tog;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  zero2one_t [N-1:0] wr_in = '0;
  zero2one_t         wr_expected = '0;
  logic              start = 1'b0;
  logic              learn_en = 1'b0;
  logic [AW:0]       n_samples = '0;
  logic [15:0]       max_epochs = '0;
  logic [23:0]       err_threshold = '0;
  logic              busy;
  logic              done;
  logic              converged;
  logic [15:0]       epoch_count;
  logic [23:0]       epoch_err;

  neuron_train_sequencer_if #(.N(N)) nlif();

  neuron_train_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_in         (wr_in),
    .wr_expected   (wr_expected),
    .start         (start),
    .learn_en      (learn_en),
    .n_samples     (n_samples),
    .max_epochs    (max_epochs),
    .err_threshold (err_threshold),
    .busy          (busy),
    .done          (done),
    .converged     (converged),
    .epoch_count   (epoch_count),
    .epoch_err     (epoch_err),
    .nl            (nlif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  zero2one_t [N-1:0] m_in  [DEPTH];
  zero2one_t         m_exp [DEPTH];
  vec_t              tv    [11];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input int n, input bit learn, input int max_ep, input int thr,
    input int out, input bit disturb, input bit simwr,
    input int simexp, input int e_err, input int e_cnt,
    input bit e_conv, input int e_lat, input int e_tog);
    vec_t v;
    v.n = n; v.learn = learn; v.max_ep = max_ep; v.thr = thr;
    v.out = out; v.disturb = disturb; v.simwr = simwr;
    v.simexp = simexp; v.e_err = e_err; v.e_cnt = e_cnt;
    v.e_conv = e_conv; v.e_lat = e_lat; v.e_tog = e_tog;
    return v;
  endfunction

  task automatic mem_wr(input int a, input zero2one_t e);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_in = m_in[a];
    wr_expected = e;
    m_exp[a] = e;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic run(input int id, input vec_t v);
    int lat, tog, pidx, bad_p, bad_b, neff, si;
    logic prev;
    logic ebusy;
    neff = (v.n > DEPTH) ? DEPTH : v.n;
    ebusy = (v.e_lat > 1);
    tog = 0; pidx = 0; bad_p = 0; bad_b = 0;
    nlif.nl_out = 8'(v.out);
    prev = nlif.nl_trigger;
    start = 1'b1;
    learn_en = v.learn;
    n_samples = (AW+1)'(v.n);
    max_epochs = 16'(v.max_ep);
    err_threshold = 24'(v.thr);
    if (v.simwr) begin
      wr_en = 1'b1;
      wr_addr = '0;
      wr_in = m_in[0];
      wr_expected = 8'(v.simexp);
      m_exp[0] = 8'(v.simexp);
    end
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b0;
    lat = 1;
    while (1) begin
      if (nlif.nl_trigger !== prev) begin
        tog++;
        prev = nlif.nl_trigger;
        if (nlif.nl_valid === 1'b1 && neff > 0) begin
          si = pidx % neff;
          if (nlif.nl_in !== m_in[si] ||
              nlif.nl_expected_out !== m_exp[si] ||
              nlif.nl_learn !== v.learn)
            bad_p++;
          pidx++;
        end else if (nlif.nl_learn !== 1'b0) begin
          bad_p++;
        end
      end
      if (done === 1'b1 || lat >= 2000) break;
      if (busy !== ebusy) bad_b++;
      if (v.disturb && lat == 5) begin
        start = 1'b1;
        wr_en = 1'b1;
        wr_addr = '0;
        wr_expected = 8'd200;
        n_samples = 1;
        max_epochs = 7;
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    $display("run %0d: latency %0d err %0d epochs %0d", id, lat,
             epoch_err, epoch_count);
    chk($sformatf("v%0d latency", id), lat, v.e_lat);
    chk($sformatf("v%0d epoch_err", id), epoch_err, v.e_err);
    chk($sformatf("v%0d epoch_count", id), epoch_count, v.e_cnt);
    chk($sformatf("v%0d converged", id), converged, v.e_conv);
    chk($sformatf("v%0d toggles", id), tog, v.e_tog);
    chk($sformatf("v%0d present_bad", id), bad_p, 0);
    chk($sformatf("v%0d busy_bad", id), bad_b, 0);
    chk($sformatf("v%0d busy_fin", id), busy, 0);
    chk($sformatf("v%0d learn_fin", id), nlif.nl_learn, 0);
    if (neff > 0 && v.max_ep > 0)
      chk($sformatf("v%0d valid_fin", id), nlif.nl_valid, 1);
    @(posedge clk); #1;
    chk($sformatf("v%0d done_pulse", id), done, 0);
  endtask

  task automatic reset_mid_run();
    int pulses, bz;
    nlif.nl_out = 8'd128;
    start = 1'b1;
    learn_en = 1'b1;
    n_samples = 4;
    max_epochs = 1;
    err_threshold = 0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst busy", busy, 1);
    chk("pre_rst valid", nlif.nl_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst valid", nlif.nl_valid, 0);
    chk("rst trigger", nlif.nl_trigger, 0);
    chk("rst learn", nlif.nl_learn, 0);
    chk("rst nl_in zero", (nlif.nl_in == '0), 1);
    chk("rst expected_out", nlif.nl_expected_out, 0);
    chk("rst converged", converged, 0);
    chk("rst epoch_err", epoch_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    bz = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
      if (busy !== 1'b0) bz++;
    end
    chk("rst no_done", pulses, 0);
    chk("rst stays_idle", bz, 0);
  endtask

  initial begin
    zero2one_t e4 [4];
    e4 = '{8'd0, 8'd255, 8'd128, 8'd100};
    for (int k = 0; k < DEPTH; k++)
      for (int j = 0; j < N; j++)
        m_in[k][j] = 8'((k * 16 + j * 7 + 3) % 256);

    tv[0]  = mk(4, 0, 1, 0, 128, 0, 0, 0, 283, 1, 0, 26, 12);
    tv[1]  = mk(4, 0, 1, 300, 128, 0, 0, 0, 283, 1, 1, 26, 12);
    tv[2]  = mk(4, 0, 0, 0, 128, 0, 0, 0, 0, 0, 0, 1, 0);
    tv[3]  = mk(4, 1, 3, 0, 128, 0, 0, 0, 283, 3, 0, 60, 20);
    tv[4]  = mk(0, 1, 3, 0, 128, 0, 0, 0, 0, 0, 0, 1, 0);
    tv[5]  = mk(40, 0, 1, 0, 128, 0, 0, 0, 283, 1, 0, 138, 40);
    tv[6]  = mk(4, 1, 2, 0, 0, 0, 0, 0, 483, 2, 0, 43, 16);
    tv[7]  = mk(4, 0, 5, 483, 0, 0, 0, 0, 483, 1, 1, 26, 12);
    tv[8]  = mk(4, 0, 1, 0, 128, 1, 0, 0, 283, 1, 0, 26, 12);
    tv[9]  = mk(4, 0, 1, 0, 128, 0, 1, 50, 233, 1, 0, 26, 12);
    tv[10] = mk(1, 1, 2, 0, 200, 0, 0, 0, 150, 2, 0, 19, 10);

    nlif.nl_out = 8'd128;
    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset converged", converged, 0);
    chk("reset epoch_count", epoch_count, 0);
    chk("reset epoch_err", epoch_err, 0);
    chk("reset trigger", nlif.nl_trigger, 0);
    chk("reset valid", nlif.nl_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < DEPTH; k++)
      mem_wr(k, (k < 4) ? e4[k] : 8'd128);

    for (int i = 0; i < 11; i++) begin
      if (i == 3) reset_mid_run();
      run(i, tv[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
